align_job_scheduler: RTL and testbench
======================================

// Module: align_job_scheduler
// PURPOSE
//  Round-robin scheduler that shares one short_solver instance between NUM_REQ requesters.
//  Sequence: accept a sequence pair, load it into the solver's inputs, hold the solver in reset
//  while the inputs settle, release it, wait for finished (with timeout), return max-score coordinates.
//  Sits between the host/request fabric and short_solver; owns the solver's rst pin.
// PARAMETERS
//  LEN1           10   seq1 length, must match short_solver len1
//  LEN2           9    seq2 length, must match short_solver len2
//  NUM_REQ        2    number of requesters, >=2
//  RST_CYCLES     2    cycles solver_rst is held high after load, >=1
//  TIMEOUT_CYCLES 256  max RUN cycles before abort, >=2
// PORTS
//  clk              in   1                        system clock
//  rst              in   1                        async active-high reset
//  req_valid        in   NUM_REQ                  per-requester job valid
//  req_ready        out  NUM_REQ                  one-hot grant/accept (combinational, IDLE only)
//  req_seq1         in   NUM_REQ x LEN1 dna_base  per-requester seq1
//  req_seq2         in   NUM_REQ x LEN2 dna_base  per-requester seq2
//  solver_rst       out  1                        drives short_solver rst (registered)
//  solver_seq1      out  LEN1 dna_base            registered seq1 to solver
//  solver_seq2      out  LEN2 dna_base            registered seq2 to solver
//  solver_finished  in   1                        short_solver finished
//  solver_maxRowId  in   $clog2(LEN1)+1           short_solver maxRowId
//  solver_maxColId  in   $clog2(LEN2)+1           short_solver maxColId
//  res_valid        out  1                        result valid
//  res_ready        in   1                        result accepted
//  res_id           out  $clog2(NUM_REQ)          index of requester the result belongs to
//  res_maxRowId     out  $clog2(LEN1)+1           captured maxRowId
//  res_maxColId     out  $clog2(LEN2)+1           captured maxColId
//  res_timeout      out  1                        1 = job aborted, ids forced to 0
//  busy             out  1                        high in every state except IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, solver_rst=1, solver_seq*=all A (encoding 0),
//   res_*=0, busy=0, last_grant=NUM_REQ-1 (so requester 0 wins first), counters=0.
//  FSM IDLE -> CLEAR -> RUN -> RESULT -> IDLE.
//  IDLE: solver_rst=1. Grant = first req_valid index searching upward from last_grant+1 (mod NUM_REQ).
//   req_ready[grant]=1 only when the grant index has req_valid=1; all other bits 0.
//   On handshake: latch req_seq1/2[grant], res_id<=grant, counter<=0, go CLEAR.
//  CLEAR: solver_rst=1 for RST_CYCLES cycles, then go RUN with solver_rst<=0.
//  RUN: solver_finished is sampled only in this state (stale finished from a prior job is ignored).
//   finished=1: capture maxRowId/ColId, res_timeout<=0, go RESULT.
//   Otherwise, counter==TIMEOUT_CYCLES-1: ids<=0, res_timeout<=1, go RESULT.
//   finished and timeout in the same cycle: finished wins.
//  RESULT: solver_rst<=1. res_valid=1 and all res_* stable until res_ready.
//   On handshake: last_grant<=res_id, res_valid<=0, go IDLE.
//   Earliest next accept is the cycle after the handshake.
//  Latency: accept at cycle T, solver released at T+RST_CYCLES+1.
//   finished seen at cycle F gives res_valid at F+1.
//  Requesters must hold req_valid and data until req_ready. Dropping valid early withdraws the
//   request with no side effects; the grant is recomputed every cycle.
//  Single job in flight. No request is accepted while busy.
//  A reset mid-job discards the job without producing a result.
// CONFIGURATION
//  ALIGN_SCHED_CYCLE_COUNT_EN defined: adds output res_cycles (16 bits).
//   Value = RUN cycles of the job; saturates at 16'hFFFF; reset 0; stable with res_valid.
//  Not defined: port absent, no counter logic beyond the timeout counter.
// TESTING (use a solver stub with programmable finished delay and ids)
//  1. Req0 ATCAGTTGGA/GGCATTGTA, stub finishes 20 cycles after release with ids 7/6
//     -> solver_seq matches; solver_rst high 2 cycles then low; res_valid with id=0, 7/6, timeout=0.
//  2. req_valid=2'b11 for four back-to-back jobs -> grants in order 0,1,0,1; exactly one req_ready bit high.
//  3. Stub never finishes -> after 256 RUN cycles res_valid=1, res_timeout=1, ids 0/0; solver_rst=1.
//  4. res_ready held low 10 cycles -> res_* stable, no new accept, busy=1; accept occurs 1 cycle after handshake.
//  5. Assert rst in RUN -> solver_rst=1 and res_valid=0 immediately; FSM in IDLE; next job starts cleanly.
//  6. With ALIGN_SCHED_CYCLE_COUNT_EN, stub finishes after 37 cycles -> res_cycles=37.

Source files
------------

// File: rtl/align_job_scheduler.sv
// Round-robin job scheduler sharing one short_solver among NUM_REQ requesters; owns solver rst.
// Optional: define ALIGN_SCHED_CYCLE_COUNT_EN to add res_cycles (saturating RUN-cycle count).
module align_job_scheduler #(
    parameter int LEN1           = 10,
    parameter int LEN2           = 9,
    parameter int NUM_REQ        = 2,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IW = $clog2(NUM_REQ),
    localparam int RW = $clog2(LEN1) + 1,
    localparam int CW = $clog2(LEN2) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][LEN1-1:0][1:0]   req_seq1,
    input  logic [NUM_REQ-1:0][LEN2-1:0][1:0]   req_seq2,
    output logic                                solver_rst,
    output logic [LEN1-1:0][1:0]                solver_seq1,
    output logic [LEN2-1:0][1:0]                solver_seq2,
    input  logic                                solver_finished,
    input  logic [RW-1:0]                       solver_maxRowId,
    input  logic [CW-1:0]                       solver_maxColId,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [IW-1:0]                       res_id,
    output logic [RW-1:0]                       res_maxRowId,
    output logic [CW-1:0]                       res_maxColId,
    output logic                                res_timeout,
    output logic                                busy
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
    ,
    output logic [15:0]                         res_cycles
`endif
);
    // one counter serves both the CLEAR hold and the RUN timeout
    localparam int TW = $clog2(TIMEOUT_CYCLES > RST_CYCLES ? TIMEOUT_CYCLES : RST_CYCLES);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESULT} state_t;
    state_t state, state_nxt;

    logic [IW-1:0] last_grant, grant;
    logic          grant_found;
    logic [TW-1:0] cnt;
    logic          clr_done, run_timeout;

    assign clr_done    = (cnt == TW'(RST_CYCLES - 1));
    assign run_timeout = (cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy        = (state != IDLE);

    // search starts just past the last served requester
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(last_grant) + 1 + i) % NUM_REQ;
            if (!grant_found && req_valid[IW'(idx)]) begin
                grant_found = 1'b1;
                grant       = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (grant_found) begin
                req_ready[grant] = 1'b1;
                state_nxt        = CLEAR;
            end
            CLEAR:   if (clr_done) state_nxt = RUN;
            RUN:     if (solver_finished || run_timeout) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
    logic [15:0] cyc_cnt, cyc_nxt;
    assign cyc_nxt = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            solver_rst   <= 1'b1;
            solver_seq1  <= '0;
            solver_seq2  <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_maxRowId <= '0;
            res_maxColId <= '0;
            res_timeout  <= 1'b0;
            last_grant   <= IW'(NUM_REQ - 1);
            cnt          <= '0;
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
            cyc_cnt      <= '0;
            res_cycles   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    solver_seq1 <= req_seq1[grant];
                    solver_seq2 <= req_seq2[grant];
                    res_id      <= grant;
                    cnt         <= '0;
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
                    cyc_cnt     <= '0;
`endif
                end
                CLEAR: begin
                    if (clr_done) begin
                        cnt        <= '0;
                        solver_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (solver_finished || run_timeout) begin
                        // finished takes priority over a coincident timeout
                        res_maxRowId <= solver_finished ? solver_maxRowId : '0;
                        res_maxColId <= solver_finished ? solver_maxColId : '0;
                        res_timeout  <= !solver_finished;
                        res_valid    <= 1'b1;
                        solver_rst   <= 1'b1;
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
                        res_cycles   <= cyc_nxt;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
                        cyc_cnt <= cyc_nxt;
`endif
                    end
                end
                RESULT: if (res_ready) begin
                    res_valid  <= 1'b0;
                    last_grant <= res_id;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_align_job_scheduler.sv
// Bench for align_job_scheduler: solver stub, vector table, reset-in-RUN sequence, random jobs vs model.
module tb_align_job_scheduler;
    localparam int RSTC = 2;
    localparam int TOUT = 256;

    logic              clk, rst;
    logic [1:0]        req_valid, req_ready;
    logic [1:0][9:0][1:0] req_seq1;
    logic [1:0][8:0][1:0] req_seq2;
    logic              solver_rst, solver_finished;
    logic [9:0][1:0]   solver_seq1;
    logic [8:0][1:0]   solver_seq2;
    logic [4:0]        solver_maxRowId, solver_maxColId;
    logic              res_valid, res_ready, res_id, res_timeout, busy;
    logic [4:0]        res_maxRowId, res_maxColId;
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
    logic [15:0]       res_cycles;
`endif

    align_job_scheduler #(.LEN1(10), .LEN2(9), .NUM_REQ(2), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_seq1(req_seq1), .req_seq2(req_seq2), .solver_rst(solver_rst),
        .solver_seq1(solver_seq1), .solver_seq2(solver_seq2), .solver_finished(solver_finished),
        .solver_maxRowId(solver_maxRowId), .solver_maxColId(solver_maxColId),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_maxRowId(res_maxRowId), .res_maxColId(res_maxColId), .res_timeout(res_timeout),
        .busy(busy)
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
        , .res_cycles(res_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // solver stub: finishes fin_delay cycles after release (0 = never), with programmed ids
    int         fin_delay, run_cnt;
    logic [4:0] stub_row, stub_col;
    always @(posedge clk) begin
        if (solver_rst) run_cnt <= 0;
        else            run_cnt <= run_cnt + 1;
    end
    assign solver_finished = !solver_rst && (fin_delay != 0) && (run_cnt == fin_delay - 1);
    assign solver_maxRowId = stub_row;
    assign solver_maxColId = stub_col;

    int total = 0, bad = 0;
    int mdl_last = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [19:0] enc(input string s);
        logic [19:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "C":     v[2*i +: 2] = 2'd1;
                "G":     v[2*i +: 2] = 2'd2;
                "T":     v[2*i +: 2] = 2'd3;
                default: v[2*i +: 2] = 2'd0;
            endcase
        end
        return v;
    endfunction

    // reference arbiter: first valid requester strictly after the last one served
    function automatic int model_grant(input logic [1:0] mask);
        for (int k = 1; k <= 2; k++) begin
            int j;
            j = (mdl_last + k) % 2;
            if (mask[j[0]]) return j;
        end
        return -1;
    endfunction

    task automatic scramble();
        logic [31:0] r;
        r = $urandom(); req_seq1[0] = r[19:0];
        r = $urandom(); req_seq1[1] = r[19:0];
        r = $urandom(); req_seq2[0] = r[17:0];
        r = $urandom(); req_seq2[1] = r[17:0];
    endtask

    task automatic job(input logic [1:0] mask, input int exp_g, input int delay,
                       input logic [4:0] row, input logic [4:0] col, input int hold,
                       input logic [19:0] s1, input logic [17:0] s2);
        int n, rel, d_eff;
        logic to;
        logic [4:0] er, ec;
        to    = (delay == 0) || (delay > TOUT);
        d_eff = to ? TOUT : delay;
        er    = to ? 5'd0 : row;
        ec    = to ? 5'd0 : col;
        fin_delay = delay; stub_row = row; stub_col = col;
        scramble();
        if (exp_g == 0) begin req_seq1[0] = s1; req_seq2[0] = s2; end
        else            begin req_seq1[1] = s1; req_seq2[1] = s2; end
        req_valid = mask;
        #1;
        check("grant", {30'd0, req_ready}, 32'd1 << exp_g);
        check("busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        scramble();
        check("busy_job", {31'd0, busy}, 32'd1);
        n = 0; rel = -1;
        while (!res_valid && n < 1000) begin
            if (rel < 0 && !solver_rst) rel = n;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, RSTC + d_eff);
        check("release", rel, RSTC);
        check("res_id", {31'd0, res_id}, exp_g);
        check("row", {27'd0, res_maxRowId}, {27'd0, er});
        check("col", {27'd0, res_maxColId}, {27'd0, ec});
        check("timeout", {31'd0, res_timeout}, {31'd0, to});
        check("solver_rst_res", {31'd0, solver_rst}, 32'd1);
        check("seq1", {12'd0, solver_seq1}, {12'd0, s1});
        check("seq2", {14'd0, solver_seq2}, {14'd0, s2});
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
        check("cycles", {16'd0, res_cycles}, d_eff);
`endif
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            req_valid = 2'b11;
            #1;
            check("hold_ready", {30'd0, req_ready}, 32'd0);
            check("hold_busy", {31'd0, busy}, 32'd1);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_row", {27'd0, res_maxRowId}, {27'd0, er});
            check("hold_id", {31'd0, res_id}, exp_g);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_drop", {31'd0, res_valid}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        mdl_last = exp_g;
    endtask

    typedef struct {
        logic [1:0] mask;
        int         g;
        int         delay;
        logic [4:0] row, col;
        int         hold;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic [19:0] s1;
        logic [17:0] s2;
        logic [31:0] r;
        tbl[0] = '{2'b11, 0, 5,   5'd3, 5'd2, 0};
        tbl[1] = '{2'b11, 1, 8,   5'd1, 5'd4, 0};
        tbl[2] = '{2'b11, 0, 3,   5'd9, 5'd8, 0};
        tbl[3] = '{2'b11, 1, 12,  5'd0, 5'd1, 0};
        tbl[4] = '{2'b01, 0, 20,  5'd7, 5'd6, 10};
        tbl[5] = '{2'b10, 1, 0,   5'd5, 5'd3, 1};
        tbl[6] = '{2'b10, 1, 256, 5'd4, 5'd4, 0};
        tbl[7] = '{2'b11, 0, 1,   5'd9, 5'd7, 2};
        tbl[8] = '{2'b11, 1, 37,  5'd5, 5'd5, 0};

        rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
        fin_delay = 0; stub_row = 5'd0; stub_col = 5'd0;
        req_seq1 = '0; req_seq2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_solver_rst", {31'd0, solver_rst}, 32'd1);
        check("rst_seq1", {12'd0, solver_seq1}, 32'd0);
        check("rst_seq2", {14'd0, solver_seq2}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_row", {27'd0, res_maxRowId}, 32'd0);
        check("rst_res_to", {31'd0, res_timeout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {30'd0, req_ready}, 32'd0);
`ifdef ALIGN_SCHED_CYCLE_COUNT_EN
        check("rst_cycles", {16'd0, res_cycles}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                s1 = enc("ATCAGTTGGA");
                s2 = enc("GGCATTGTA") & 20'h3FFFF;
            end else begin
                r = $urandom(); s1 = r[19:0];
                r = $urandom(); s2 = r[17:0];
            end
            job(tbl[i].mask, tbl[i].g, tbl[i].delay, tbl[i].row, tbl[i].col, tbl[i].hold, s1, s2);
        end

        // reset while the solver is running: job vanishes, arbiter pointer restarts
        fin_delay = 0;
        req_valid = 2'b11;
        #1;
        check("rst_job_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_run", {31'd0, solver_rst}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_solver_rst", {31'd0, solver_rst}, 32'd1);
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        #3;
        rst = 1'b0;
        mdl_last = 1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'd0, res_valid}, 32'd0);
        r = $urandom(); s1 = r[19:0];
        r = $urandom(); s2 = r[17:0];
        job(2'b11, model_grant(2'b11), 6, 5'd2, 5'd3, 0, s1, s2);

        for (int i = 0; i < 25; i++) begin
            logic [1:0] m;
            logic [4:0] rr, cc;
            r  = $urandom_range(1, 3); m = r[1:0];
            r  = $urandom();           rr = r[4:0]; cc = r[12:8];
            r = $urandom(); s1 = r[19:0];
            r = $urandom(); s2 = r[17:0];
            job(m, model_grant(m), $urandom_range(1, 40), rr, cc, $urandom_range(0, 3), s1, s2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
